sseg_scan_driver: RTL and testbench

- Parametrised successor to the team's 4-digit display driver.
- Multiplexes NUM_DIGITS BCD/hex digits onto one shared 7-segment bus plus a colon.
- Adds per-frame input snapshot (tear-free), anti-ghost blank cycle, leading-zero blanking, setup-location digit blink and colon blink.
- Sits between the timekeeping/mode logic and the board SSEG pins.

---
 rtl/sseg_scan_driver.sv | 192 +++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed 7-segment scan driver: NUM_DIGITS hex digits plus colon on one shared bus,
// with per-frame input snapshot, anti-ghost blank slot edge, leading-zero blanking and blink.
module sseg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lead,
    input  logic                      blink_en,
    input  logic [2:0]                blink_sel,
    input  logic [1:0]                colon_mode,
    output logic [7:0]                SSEG,
    output logic [NUM_DIGITS-1:0]     SSEGD,
    output logic                      SSEG_COL,
    output logic                      frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    // Active-high segment pattern, bit0=a .. bit6=g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_r;
    logic [2:0]              idx_r;
    logic [FRM_W-1:0]        frm_cnt_r;
    logic                    blink_phase_r;
    logic [4*NUM_DIGITS-1:0] snap_digits_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic                    snap_blank_lead_r;
    logic                    snap_blink_en_r;
    logic [2:0]              snap_blink_sel_r;
    logic [1:0]              snap_colon_mode_r;
    logic [7:0]              sseg_r;
    logic [NUM_DIGITS-1:0]   ssegd_r;
    logic                    col_r;
    logic                    frame_tick_r;

    logic                    scan_tick_s;
    logic                    frame_s;
    logic [3:0]              cur_digit_s;
    logic                    cur_dp_s;
    logic                    nonzero_s;
    logic [NUM_DIGITS-1:0]   anode_s;
    logic                    lead_zero_s;
    logic                    blink_off_s;
    logic                    suppress_s;
    logic                    col_s;

    assign scan_tick_s = (cnt_r == CNT_LAST);
    assign frame_s     = scan_tick_s && (idx_r == IDX_LAST);

    // Slot prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (scan_tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Digit index, frame pulse and the tear-free input snapshot taken at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r             <= 3'd0;
            frame_tick_r      <= 1'b0;
            snap_digits_r     <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_r         <= {NUM_DIGITS{1'b0}};
            snap_blank_lead_r <= 1'b0;
            snap_blink_en_r   <= 1'b0;
            snap_blink_sel_r  <= 3'd0;
            snap_colon_mode_r <= 2'b00;
        end else begin
            frame_tick_r <= frame_s;
            if (frame_s) begin
                idx_r             <= 3'd0;
                snap_digits_r     <= digits;
                snap_dp_r         <= dp_in;
                snap_blank_lead_r <= blank_lead;
                snap_blink_en_r   <= blink_en;
                snap_blink_sel_r  <= blink_sel;
                snap_colon_mode_r <= colon_mode;
            end else if (scan_tick_s) begin
                idx_r <= idx_r + 3'd1;
            end
        end
    end

    // Blink timebase: phase flips every BLINK_FRAMES frames, aligned with the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_r     <= {FRM_W{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (frame_s) begin
            if (frm_cnt_r == FRM_LAST) begin
                frm_cnt_r     <= {FRM_W{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frm_cnt_r <= frm_cnt_r + FRM_W'(1);
            end
        end
    end

    // Select the current digit and detect whether it and everything left of it is zero.
    always_comb begin
        cur_digit_s = 4'h0;
        cur_dp_s    = 1'b0;
        nonzero_s   = 1'b0;
        anode_s     = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_r == 3'(k)) begin
                cur_digit_s = snap_digits_r[4*k +: 4];
                cur_dp_s    = snap_dp_r[k];
                anode_s[k]  = 1'b0;
            end else begin
                anode_s[k]  = 1'b1;
            end
            if ((3'(k) >= idx_r) && (snap_digits_r[4*k +: 4] != 4'h0)) begin
                nonzero_s = 1'b1;
            end else begin
                nonzero_s = nonzero_s;
            end
        end
    end

    // Suppression and colon decisions, all from snapshot state.
    always_comb begin
        lead_zero_s = snap_blank_lead_r && (idx_r != 3'd0) && !nonzero_s;
        blink_off_s = snap_blink_en_r && (snap_blink_sel_r == idx_r) && !blink_phase_r;
        suppress_s  = lead_zero_s || blink_off_s;
        case (snap_colon_mode_r)
            2'b01:   col_s = 1'b0;
            2'b10:   col_s = ~blink_phase_r;
            default: col_s = 1'b1;
        endcase
    end

    // Registered pins; the scan_tick cycle blanks the bus so the previous digit never ghosts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_r  <= 8'hFF;
            ssegd_r <= {NUM_DIGITS{1'b1}};
            col_r   <= 1'b1;
        end else begin
            col_r <= col_s;
            if (scan_tick_s || suppress_s) begin
                sseg_r  <= 8'hFF;
                ssegd_r <= {NUM_DIGITS{1'b1}};
            end else begin
                sseg_r  <= {~cur_dp_s, ~seg_decode(cur_digit_s)};
                ssegd_r <= anode_s;
            end
        end
    end

    assign SSEG       = sseg_r;
    assign SSEGD      = ssegd_r;
    assign SSEG_COL   = col_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: directed scenarios plus random input churn, checked every cycle
// against a model that derives slot, frame and blink phase from the edge count since reset.
module tb_sseg_scan_driver;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * S;
    localparam int MAXF  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lead = 1'b0;
    logic        blink_en = 1'b0;
    logic [2:0]  blink_sel = 3'd0;
    logic [1:0]  colon_mode = 2'b00;
    logic [7:0]  SSEG;
    logic [3:0]  SSEGD;
    logic        SSEG_COL;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    // Inputs as captured at each frame boundary; frame 0 is the all-zero reset snapshot.
    logic [15:0] s_dig [MAXF];
    logic [3:0]  s_dp  [MAXF];
    logic        s_bl  [MAXF];
    logic        s_be  [MAXF];
    logic [2:0]  s_bs  [MAXF];
    logic [1:0]  s_cm  [MAXF];

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sseg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_lead (blank_lead),
        .blink_en   (blink_en),
        .blink_sel  (blink_sel),
        .colon_mode (colon_mode),
        .SSEG       (SSEG),
        .SSEGD      (SSEGD),
        .SSEG_COL   (SSEG_COL),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, e, obs, exp_v);
        end
    endtask

    task automatic check_reset_pins();
        chk("rst_sseg",  32'(SSEG),       32'h0000_00FF);
        chk("rst_ssegd", 32'(SSEGD),      32'h0000_000F);
        chk("rst_col",   32'(SSEG_COL),   32'd1);
        chk("rst_ftick", 32'(frame_tick), 32'd0);
    endtask

    // One clock: record the frame snapshot if this edge is a frame boundary, then check all pins.
    task automatic step();
        int          p, f, idx;
        logic [15:0] sh;
        logic [3:0]  d;
        logic        phase, off;
        logic [7:0]  xs;
        logic [3:0]  xa;
        logic        xc;
        @(posedge clk);
        e++;
        if (e % FRAME == 0) begin
            f = e / FRAME;
            s_dig[f] = digits;
            s_dp[f]  = dp_in;
            s_bl[f]  = blank_lead;
            s_be[f]  = blink_en;
            s_bs[f]  = blink_sel;
            s_cm[f]  = colon_mode;
        end
        #1;
        p     = e - 1;
        f     = p / FRAME;
        idx   = (p / S) % N;
        phase = ((f / BF) % 2) == 0;
        sh    = s_dig[f] >> (4 * idx);
        d     = sh[3:0];
        off   = (p % S == S - 1) ||
                (s_bl[f] && idx > 0 && sh == 16'h0000) ||
                (s_be[f] && int'(s_bs[f]) == idx && !phase);
        if (off) begin
            xs = 8'hFF;
            xa = 4'hF;
        end else begin
            xs = {~s_dp[f][idx], ~pat[d]};
            xa = ~(4'b0001 << idx);
        end
        case (s_cm[f])
            2'b01:   xc = 1'b0;
            2'b10:   xc = ~phase;
            default: xc = 1'b1;
        endcase
        chk("sseg",  32'(SSEG),       32'(xs));
        chk("ssegd", 32'(SSEGD),      32'(xa));
        chk("col",   32'(SSEG_COL),   32'(xc));
        chk("ftick", 32'(frame_tick), (e % FRAME == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Advance until at least min_frame frames have started and the scan sits on digit target.
    task automatic run_until(input int min_frame, input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            step();
            if ((e / FRAME) >= min_frame && (e / S) % N == target) found = 1'b1;
        end
        chk("reach_idx", 32'(found), 32'd1);
    endtask

    task automatic rand_inputs();
        logic [15:0] mask;
        case ($urandom_range(0, 4))
            0:       mask = 16'h000F;
            1:       mask = 16'h00FF;
            2:       mask = 16'h0FFF;
            3:       mask = 16'h0000;
            default: mask = 16'hFFFF;
        endcase
        digits     = 16'($urandom) & mask;
        dp_in      = 4'($urandom);
        blank_lead = 1'($urandom);
        blink_en   = 1'($urandom);
        blink_sel  = 3'($urandom_range(0, 7));
        colon_mode = 2'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_dig[0] = 16'h0000; s_dp[0] = 4'h0; s_bl[0] = 1'b0;
        s_be[0]  = 1'b0;     s_bs[0] = 3'd0; s_cm[0] = 2'b00;

        repeat (2) @(negedge clk);
        check_reset_pins();
        @(negedge clk);
        rst = 1'b0;
        e   = 0;

        // Basic scan, then a mid-frame change that must wait for the next frame.
        digits = 16'h1234;
        run_until(1, 2);
        digits = 16'h5678;
        run(2 * FRAME);

        // Leading-zero blanking.
        blank_lead = 1'b1;
        digits     = 16'h0070;
        run(2 * FRAME);
        digits = 16'h0000;
        run(2 * FRAME);
        blank_lead = 1'b0;

        // Hex decode with a decimal point.
        digits = 16'hFA00;
        dp_in  = 4'b0100;
        run(2 * FRAME);
        dp_in  = 4'b0000;

        // Setup blink with blinking colon, then an out-of-range blink index.
        digits     = 16'h1234;
        blink_en   = 1'b1;
        blink_sel  = 3'd2;
        colon_mode = 2'b10;
        run(6 * FRAME);
        blink_sel  = 3'd5;
        run(4 * FRAME);
        colon_mode = 2'b01;
        run(2 * FRAME);

        // Random churn, changes landing anywhere inside a frame.
        for (int i = 0; i < 100 * FRAME; i++) begin
            step();
            if ($urandom_range(0, 9) == 0) rand_inputs();
        end

        // Asynchronous reset between clock edges while digit 3 is being scanned.
        digits     = 16'h9876;
        colon_mode = 2'b01;
        run(2 * FRAME);
        run_until(0, 3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_pins();
        repeat (2) @(posedge clk);
        #1;
        check_reset_pins();
        @(negedge clk);
        rst = 1'b0;
        e   = 0;
        run(4 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
